lt24_pixel_bus: RTL and testbench

//  Responder side of the LT24 pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).

---
 rtl/lt24_pixel_bus_if.sv | 33 +++
 rtl/lt24_pixel_bus.sv | 252 +++++++++++++++++++++++++
 tb/tb_lt24_pixel_bus.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lt24_pixel_bus_if.sv
// Purpose : Pixel-side handshake and LT24 pin bundle for lt24_pixel_bus.
// Signals : displayOn, xAddr[7:0], yAddr[8:0], pixelData[15:0], pixelWrite -> responder
//           pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data[15:0] <- responder
//           pixelRawMode -> responder (only when LT24_PIXEL_RAW_MODE_EN is defined)
// Modports: master = pixel generator side, slave = lt24_pixel_bus.
interface lt24_pixel_bus_if;
  logic        displayOn;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
`ifdef LT24_PIXEL_RAW_MODE_EN
  logic        pixelRawMode;
`endif
  logic        LT24CS_n;
  logic        LT24RS;
  logic        LT24Wr_n;
  logic        LT24Rd_n;
  logic [15:0] LT24Data;

`ifdef LT24_PIXEL_RAW_MODE_EN
  modport master (output displayOn, xAddr, yAddr, pixelData, pixelWrite, pixelRawMode,
                  input  pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data);
  modport slave  (input  displayOn, xAddr, yAddr, pixelData, pixelWrite, pixelRawMode,
                  output pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data);
`else
  modport master (output displayOn, xAddr, yAddr, pixelData, pixelWrite,
                  input  pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data);
  modport slave  (input  displayOn, xAddr, yAddr, pixelData, pixelWrite,
                  output pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24Data);
`endif
endinterface

// File: rtl/lt24_pixel_bus.sv
// Purpose : Responder for the LT24 pixel interface. Accepts one pixel per handshake and
//           emits 8080-style write cycles, sending the column/row window commands only when
//           the pixel does not follow on from the panel's own address pointer.
// Ports   : clock  - system clock
//           reset  - asynchronous, active-high
//           bus    - lt24_pixel_bus_if.slave (pixel handshake in, LT24 pins out)
// Options : LT24_PIXEL_RAW_MODE_EN adds bus.pixelRawMode; a raw transfer sends pixelData as
//           one word with RS = xAddr[0] and invalidates the continuity tracker.
module lt24_pixel_bus #(
  parameter int unsigned LCD_WIDTH      = 240,
  parameter int unsigned LCD_HEIGHT     = 320,
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset,
  lt24_pixel_bus_if.slave bus
);

  localparam int unsigned CNT_MAX  = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES
                                                                      : WR_HIGH_CYCLES;
  localparam int unsigned CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LO_LAST = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HI_LAST = CW'(WR_HIGH_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX = 4'd11;
  localparam logic [7:0]  X_LAST   = 8'(LCD_WIDTH - 1);
  localparam logic [8:0]  Y_LAST   = 9'(LCD_HEIGHT - 1);
  localparam logic [15:0] W_END    = 16'(LCD_WIDTH - 1);
  localparam logic [15:0] H_END    = 16'(LCD_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_STROBE_LO, S_STROBE_HI} state_t;

  // Word idx of the 12-word jump sequence as {RS, data}; idx 11 is the pixel itself,
  // so a streamed pixel is simply a sequence that starts at idx 11.
  function automatic logic [16:0] word_at(input logic [3:0] idx, input logic [7:0] x,
                                          input logic [8:0] y, input logic [15:0] d);
    logic [16:0] w;
    case (idx)
      4'd0:    w = {1'b0, 16'h002A};
      4'd1:    w = {1'b1, 16'({8'd0, x} >> 8)};
      4'd2:    w = {1'b1, 8'h00, x};
      4'd3:    w = {1'b1, 8'h00, W_END[15:8]};
      4'd4:    w = {1'b1, 8'h00, W_END[7:0]};
      4'd5:    w = {1'b0, 16'h002B};
      4'd6:    w = {1'b1, 16'({7'd0, y} >> 8)};
      4'd7:    w = {1'b1, 8'h00, y[7:0]};
      4'd8:    w = {1'b1, 8'h00, H_END[15:8]};
      4'd9:    w = {1'b1, 8'h00, H_END[7:0]};
      4'd10:   w = {1'b0, 16'h002C};
      default: w = {1'b1, d};
    endcase
    return w;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_rs, w_rs_nxt;
  logic          r_wr_n, w_wr_n_nxt;
  logic          r_rd_n;
  logic [15:0]   r_data, w_data_nxt;
  logic [7:0]    r_x, w_x_nxt;
  logic [8:0]    r_y, w_y_nxt;
  logic [15:0]   r_pix, w_pix_nxt;
  logic          r_raw, w_raw_nxt;
  logic [7:0]    r_win_x, w_win_x_nxt;
  logic [8:0]    r_win_y, w_win_y_nxt;
  logic [7:0]    r_next_x, w_next_x_nxt;
  logic [8:0]    r_next_y, w_next_y_nxt;
  logic          r_cont, w_cont_nxt;
  logic [16:0]   w_word;
  logic          w_raw_req;
  logic          w_xfer;
  logic          w_in_range;
  logic          w_contig;

`ifdef LT24_PIXEL_RAW_MODE_EN
  assign w_raw_req = bus.pixelRawMode;
`else
  assign w_raw_req = 1'b0;
`endif

  assign w_xfer     = bus.pixelWrite && r_ready;
  assign w_in_range = (32'(bus.xAddr) < LCD_WIDTH) && (32'(bus.yAddr) < LCD_HEIGHT);
  assign w_contig   = r_cont && (bus.xAddr == r_next_x) && (bus.yAddr == r_next_y);

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ready  <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rs     <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_data   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_pix    <= '0;
      r_raw    <= 1'b0;
      r_win_x  <= '0;
      r_win_y  <= '0;
      r_next_x <= '0;
      r_next_y <= '0;
      r_cont   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_ready  <= w_ready_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_rs     <= w_rs_nxt;
      r_wr_n   <= w_wr_n_nxt;
      r_rd_n   <= 1'b1;
      r_data   <= w_data_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_pix    <= w_pix_nxt;
      r_raw    <= w_raw_nxt;
      r_win_x  <= w_win_x_nxt;
      r_win_y  <= w_win_y_nxt;
      r_next_x <= w_next_x_nxt;
      r_next_y <= w_next_y_nxt;
      r_cont   <= w_cont_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_ready_nxt  = r_ready;
    w_cs_n_nxt   = r_cs_n;
    w_rs_nxt     = r_rs;
    w_wr_n_nxt   = r_wr_n;
    w_data_nxt   = r_data;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_pix_nxt    = r_pix;
    w_raw_nxt    = r_raw;
    w_win_x_nxt  = r_win_x;
    w_win_y_nxt  = r_win_y;
    w_next_x_nxt = r_next_x;
    w_next_y_nxt = r_next_y;
    w_cont_nxt   = r_cont;
    w_word       = '0;

    unique case (r_state)
      S_IDLE: begin
        w_ready_nxt = bus.displayOn;
        w_cs_n_nxt  = 1'b1;
        if (w_xfer) begin
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
          if (w_raw_req) begin
            w_raw_nxt   = 1'b1;
            w_cont_nxt  = 1'b0;
            w_idx_nxt   = LAST_IDX;
            w_rs_nxt    = bus.xAddr[0];
            w_data_nxt  = bus.pixelData;
            w_cs_n_nxt  = 1'b0;
            w_wr_n_nxt  = 1'b0;
            w_state_nxt = S_STROBE_LO;
          end else if (!w_in_range) begin
            w_state_nxt = S_DROP;
          end else begin
            w_raw_nxt = 1'b0;
            w_x_nxt   = bus.xAddr;
            w_y_nxt   = bus.yAddr;
            w_pix_nxt = bus.pixelData;
            if (w_contig) begin
              w_idx_nxt = LAST_IDX;
            end else begin
              w_idx_nxt   = '0;
              w_win_x_nxt = bus.xAddr;
              w_win_y_nxt = bus.yAddr;
            end
            w_word                 = word_at(w_idx_nxt, bus.xAddr, bus.yAddr, bus.pixelData);
            {w_rs_nxt, w_data_nxt} = w_word;
            w_cs_n_nxt             = 1'b0;
            w_wr_n_nxt             = 1'b0;
            w_state_nxt            = S_STROBE_LO;
          end
        end
      end

      // Out-of-range pixel: one idle cycle, tracker untouched
      S_DROP: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = bus.displayOn;
      end

      S_STROBE_LO: begin
        if (r_cnt == LO_LAST) begin
          w_cnt_nxt   = '0;
          w_wr_n_nxt  = 1'b1;
          w_state_nxt = S_STROBE_HI;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_STROBE_HI: begin
        if (r_cnt == HI_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_IDLE;
            w_cs_n_nxt  = 1'b1;
            w_ready_nxt = bus.displayOn;
            // Track where the panel's write pointer now sits
            if (!r_raw) begin
              w_cont_nxt = 1'b1;
              if (r_x < X_LAST) begin
                w_next_x_nxt = r_x + 8'd1;
                w_next_y_nxt = r_y;
              end else if (r_y < Y_LAST) begin
                w_next_x_nxt = r_win_x;
                w_next_y_nxt = r_y + 9'd1;
              end else begin
                w_next_x_nxt = r_win_x;
                w_next_y_nxt = r_win_y;
              end
            end
          end else begin
            w_idx_nxt              = r_idx + 4'd1;
            w_word                 = word_at(w_idx_nxt, r_x, r_y, r_pix);
            {w_rs_nxt, w_data_nxt} = w_word;
            w_wr_n_nxt             = 1'b0;
            w_state_nxt            = S_STROBE_LO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.pixelReady = r_ready;
  assign bus.LT24CS_n   = r_cs_n;
  assign bus.LT24RS     = r_rs;
  assign bus.LT24Wr_n   = r_wr_n;
  assign bus.LT24Rd_n   = r_rd_n;
  assign bus.LT24Data   = r_data;

endmodule

// File: tb/tb_lt24_pixel_bus.sv
// Purpose : Self-checking bench for lt24_pixel_bus: directed vector table, frame-wrap stream,
//           randomized pixels against a pixel-level model, mid-sequence reset, displayOn drop.
module tb_lt24_pixel_bus;
  localparam int unsigned W  = 240;
  localparam int unsigned H  = 320;
  localparam int unsigned LO = 2;
  localparam int unsigned HI = 2;
  localparam int          MEMSZ = 8192;

  logic clock = 1'b0;
  logic reset;
  lt24_pixel_bus_if bus();

  lt24_pixel_bus #(.LCD_WIDTH(W), .LCD_HEIGHT(H), .WR_LOW_CYCLES(LO), .WR_HIGH_CYCLES(HI))
    dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

`ifdef LT24_PIXEL_RAW_MODE_EN
  initial bus.pixelRawMode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Every latched bus word, as {CS_n, RS, data} at the Wr_n rising edge
  logic [17:0] got_mem [MEMSZ];
  int          got_n = 0;
  int          rd_ptr = 0;
  int          cs_falls = 0;
  always @(posedge bus.LT24Wr_n) begin
    if (reset === 1'b0) begin
      got_mem[got_n % MEMSZ] = {bus.LT24CS_n, bus.LT24RS, bus.LT24Data};
      got_n++;
    end
  end
  always @(negedge bus.LT24CS_n) cs_falls++;

  // Pixel-level reference: panel pointer tracking and expected word stream
  bit          m_cont;
  int          m_nx, m_ny, m_wx, m_wy;
  logic [17:0] exp_q [$];

  function automatic int model_pixel(input int x, input int y, input logic [15:0] d);
    int n;
    if (x >= int'(W) || y >= int'(H)) return 2;
    if (m_cont && x == m_nx && y == m_ny) begin
      exp_q.push_back({2'b01, d});
      n = 1;
    end else begin
      exp_q.push_back({2'b00, 16'h002A});
      exp_q.push_back({2'b01, 16'(x / 256)});
      exp_q.push_back({2'b01, 16'(x % 256)});
      exp_q.push_back({2'b01, 16'((W - 1) / 256)});
      exp_q.push_back({2'b01, 16'((W - 1) % 256)});
      exp_q.push_back({2'b00, 16'h002B});
      exp_q.push_back({2'b01, 16'(y / 256)});
      exp_q.push_back({2'b01, 16'(y % 256)});
      exp_q.push_back({2'b01, 16'((H - 1) / 256)});
      exp_q.push_back({2'b01, 16'((H - 1) % 256)});
      exp_q.push_back({2'b00, 16'h002C});
      exp_q.push_back({2'b01, d});
      m_wx = x;
      m_wy = y;
      n = 12;
    end
    if (x < int'(W) - 1) begin
      m_nx = x + 1; m_ny = y;
    end else if (y < int'(H) - 1) begin
      m_nx = m_wx;  m_ny = y + 1;
    end else begin
      m_nx = m_wx;  m_ny = m_wy;
    end
    m_cont = 1'b1;
    return n * int'(LO + HI) + 1;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_words(input string name);
    int n;
    int m;
    n = got_n - rd_ptr;
    check_eq({name, " count"}, 32'(n), 32'(exp_q.size()));
    m = (n < exp_q.size()) ? n : exp_q.size();
    for (int i = 0; i < m; i++)
      check_eq($sformatf("%s word%0d", name, i), 32'(got_mem[(rd_ptr + i) % MEMSZ]),
               32'(exp_q[i]));
    rd_ptr = got_n;
    exp_q.delete();
  endtask

  // Called at posedge+1; leaves at posedge+1 of the cycle after the transfer
  task automatic start_pixel(input int x, input int y, input logic [15:0] d, output bit ok);
    int n;
    n = 0;
    while (bus.pixelReady !== 1'b1 && n < 300) begin
      @(posedge clock); #1; n++;
    end
    if (bus.pixelReady !== 1'b1) begin
      checks++; errors++;
      $display("FAIL handshake timeout: pixelReady=%b required 1", bus.pixelReady);
      ok = 1'b0;
      return;
    end
    bus.xAddr      = 8'(x);
    bus.yAddr      = 9'(y);
    bus.pixelData  = d;
    bus.pixelWrite = 1'b1;
    @(posedge clock); #1;
    bus.pixelWrite = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (bus.pixelReady !== 1'b1 && n < 200) begin
      @(posedge clock); #1; n++;
    end
  endtask

  // want < 0: latency from the model; otherwise a fixed expected latency
  task automatic do_pixel(input int x, input int y, input logic [15:0] d, input string name,
                          input int want);
    int  lat;
    int  n;
    bit  ok;
    lat = model_pixel(x, y, d);
    if (want >= 0) lat = want;
    start_pixel(x, y, d, ok);
    if (ok) begin
      wait_ready(n);
      check_eq({name, " latency"}, 32'(n), 32'(lat));
      check_words(name);
    end else begin
      exp_q.delete();
      rd_ptr = got_n;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq(name, {12'd0, bus.pixelReady, bus.LT24CS_n, bus.LT24RS, bus.LT24Wr_n,
                    bus.LT24Rd_n, bus.LT24Data}, {12'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0});
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [15:0] d;
    int          lat;
    int          nw;
  } vec_t;

  vec_t        vecs [12];
  logic [17:0] t1 [12];

  initial begin
    int  n;
    int  lat;
    int  falls0;
    int  ready_hi;
    bit  ok;
    int  x, y, r;

    vecs[0]  = '{1,   0,   16'h07E0, 5,  1};
    vecs[1]  = '{2,   0,   16'h001F, 5,  1};
    vecs[2]  = '{10,  5,   16'h1234, 49, 12};
    vecs[3]  = '{11,  5,   16'h5678, 5,  1};
    vecs[4]  = '{50,  5,   16'h9ABC, 49, 12};
    vecs[5]  = '{240, 0,   16'hFFFF, 2,  0};
    vecs[6]  = '{51,  5,   16'h1111, 5,  1};
    vecs[7]  = '{0,   320, 16'h2222, 2,  0};
    vecs[8]  = '{52,  5,   16'h3333, 5,  1};
    vecs[9]  = '{239, 5,   16'h4444, 49, 12};
    vecs[10] = '{239, 6,   16'h5555, 5,  1};
    vecs[11] = '{0,   0,   16'h6666, 49, 12};
    t1 = '{18'h0002A, 18'h10000, 18'h10000, 18'h10000, 18'h100EF, 18'h0002B,
           18'h10000, 18'h10000, 18'h10001, 18'h1003F, 18'h0002C, 18'h1F800};

    reset          = 1'b1;
    bus.displayOn  = 1'b0;
    bus.pixelWrite = 1'b0;
    bus.xAddr      = '0;
    bus.yAddr      = '0;
    bus.pixelData  = '0;
    m_cont = 1'b0; m_nx = 0; m_ny = 0; m_wx = 0; m_wy = 0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset values");
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("ready with displayOn low", 32'(bus.pixelReady), 32'd0);
    bus.displayOn = 1'b1;
    @(posedge clock); #1;
    check_eq("ready after displayOn", 32'(bus.pixelReady), 32'd1);

    // First pixel after reset: full window jump
    lat = model_pixel(0, 0, 16'hF800);
    start_pixel(0, 0, 16'hF800, ok);
    wait_ready(n);
    check_eq("first latency", 32'(n), 32'd49);
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("first word%0d", i), 32'(got_mem[(rd_ptr + i) % MEMSZ]), 32'(t1[i]));
    check_words("first");

    // Directed table: stream, jump, drops and continuity across drops
    for (int i = 0; i < 12; i++) begin
      falls0 = cs_falls;
      do_pixel(vecs[i].x, vecs[i].y, vecs[i].d, $sformatf("vec%0d", i), vecs[i].lat);
      if (vecs[i].nw == 0)
        check_eq($sformatf("vec%0d no CS", i), 32'(cs_falls - falls0), 32'd0);
    end

    // Stream through the last two rows and wrap back to the window origin
    do_pixel(200, 318, 16'hA5A5, "wrap jump", -1);
    for (int i = 0; i < 79; i++)
      do_pixel(m_nx, m_ny, 16'($urandom), "wrap stream", 5);
    do_pixel(200, 318, 16'h5A5A, "wrap frame", 5);

    // Randomized pixels against the model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6 && m_cont) begin
        x = m_nx; y = m_ny;
      end else if (r == 6) begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(320, 511));
      end else if (r == 7) begin
        x = int'($urandom_range(240, 255));
        y = int'($urandom_range(0, 319));
      end else begin
        x = int'($urandom_range(0, 239));
        y = int'($urandom_range(0, 319));
      end
      do_pixel(x, y, 16'($urandom), "rand", -1);
    end

    // Reset during word 6 of a jump clears the continuity tracker
    do_pixel(0, 0, 16'hAAAA, "pre reset", -1);
    start_pixel(7, 7, 16'h7777, ok);
    n = 0;
    while ((got_n - rd_ptr) < 5 && n < 300) begin
      @(posedge clock); #1; n++;
    end
    check_eq("words before reset", 32'(got_n - rd_ptr), 32'd5);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs("mid-sequence reset");
    @(posedge clock); #1;
    reset  = 1'b0;
    m_cont = 1'b0;
    rd_ptr = got_n;
    exp_q.delete();
    do_pixel(1, 0, 16'hBEEF, "post reset", 49);

    // displayOn falls mid-jump: sequence completes, ready held low
    lat = model_pixel(30, 40, 16'hC0DE);
    start_pixel(30, 40, 16'hC0DE, ok);
    n = 0;
    while ((got_n - rd_ptr) < 3 && n < 100) begin
      @(posedge clock); #1; n++;
    end
    bus.displayOn = 1'b0;
    ready_hi = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clock); #1;
      if (bus.pixelReady === 1'b1) ready_hi++;
    end
    check_eq("displayOn low ready", 32'(ready_hi), 32'd0);
    check_words("displayOn low");
    bus.displayOn = 1'b1;
    @(posedge clock); #1;
    check_eq("displayOn rise ready", 32'(bus.pixelReady), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
